// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational ALU between two requesters. A request is accepted
// in IDLE (round-robin when both ports are valid), its fields are registered
// and held on the alu_* outputs for the whole EXEC state, and the ALU result
// is captured into rsp_data and returned to the winning port in RESP.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is only offered in IDLE, to the granted port only.
// rsp_valid stays high, with rsp_data stable, until the owner's rsp_ready is
// seen; the other port's rsp_ready is ignored.
//
// Optional feature (compile-time macro ALU_SHARE_MUL_WAIT_EN):
//   defined   - MUL (opcode 6'b011100) holds EXEC for MUL_CYCLES cycles.
//   undefined - every opcode uses one EXEC cycle; no hold counter exists.
//
// Parameters:
//   DATA_W      operand/result width
//   MUL_CYCLES  EXEC cycles for MUL when the feature is built in (1..15)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]   per-port request handshake
//   req_op1_i, req_op2_i        operands of port i
//   req_opcode_i, req_ar_op_i   opcode / funct fields of port i
//   req_shamt_i                 shift amount of port i
//   alu_op1/op2/opcode/ar_op/shamt  registered fields driven to the ALU
//   alu_result                  ALU data_out_alu
//   rsp_valid/rsp_ready [1:0]   per-port response handshake
//   rsp_data                    result register
//   busy                        high whenever not in IDLE
//   dbg_state                   FSM state (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_op1_0,
    input  logic [DATA_W-1:0] req_op2_0,
    input  logic [DATA_W-1:0] req_op1_1,
    input  logic [DATA_W-1:0] req_op2_1,
    input  logic [5:0]        req_opcode_0,
    input  logic [5:0]        req_ar_op_0,
    input  logic [5:0]        req_opcode_1,
    input  logic [5:0]        req_ar_op_1,
    input  logic [4:0]        req_shamt_0,
    input  logic [4:0]        req_shamt_1,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [5:0]        alu_opcode,
    output logic [5:0]        alu_ar_op,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic [1:0]        rsp_ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Out-of-range MUL_CYCLES is a configuration error in either build.
    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("alu_share_ctrl: MUL_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    logic              prio;
    logic              owner;
    logic              busy_q;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [5:0]        opcode_q;
    logic [5:0]        ar_op_q;
    logic [4:0]        shamt_q;
    logic [DATA_W-1:0] rsp_data_q;

    // Combinational grant: a lone requester wins, a tie goes to prio.
    logic              grant;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;
    logic [5:0]        sel_opcode;
    logic [5:0]        sel_ar_op;
    logic [4:0]        sel_shamt;
    logic              exec_done;

    assign grant = (req_valid == 2'b11) ? prio : req_valid[1];

    // rst_n gating keeps req_ready low for the whole reset pulse.
    assign req_ready[0] = rst_n && (state == S_IDLE) && req_valid[0] && !grant;
    assign req_ready[1] = rst_n && (state == S_IDLE) && req_valid[1] && grant;

    assign sel_op1    = grant ? req_op1_1    : req_op1_0;
    assign sel_op2    = grant ? req_op2_1    : req_op2_0;
    assign sel_opcode = grant ? req_opcode_1 : req_opcode_0;
    assign sel_ar_op  = grant ? req_ar_op_1  : req_ar_op_0;
    assign sel_shamt  = grant ? req_shamt_1  : req_shamt_0;

`ifdef ALU_SHARE_MUL_WAIT_EN
    localparam logic [5:0] MUL_OPCODE = 6'b011100;
    localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 1);

    // Remaining extra EXEC cycles; the result is taken when it reaches 0.
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (state == S_IDLE && (|req_ready)) begin
            cnt <= (sel_opcode == MUL_OPCODE) ? MUL_LOAD : 4'd0;
        end else if (state == S_EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign exec_done = (cnt == 4'd0);
`else
    assign exec_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
            op1_q       <= '0;
            op2_q       <= '0;
            opcode_q    <= '0;
            ar_op_q     <= '0;
            shamt_q     <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_ready) begin
                        op1_q    <= sel_op1;
                        op2_q    <= sel_op2;
                        opcode_q <= sel_opcode;
                        ar_op_q  <= sel_ar_op;
                        shamt_q  <= sel_shamt;
                        owner    <= grant;
                        prio     <= ~grant;
                        busy_q   <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        rsp_data_q  <= alu_result;
                        rsp_valid_q <= owner ? 2'b10 : 2'b01;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_opcode = opcode_q;
    assign alu_ar_op  = ar_op_q;
    assign alu_shamt  = shamt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = busy_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
//
// Self-checking bench for alu_share_ctrl. A behavioural ALU is attached to the
// alu_* outputs; expected results come from a constant vector table or from
// the same ALU function applied to the request fields, so a mis-routed field
// shows up as a wrong result. Round-robin order is tracked by remembering the
// last granted port. Build with or without ALU_SHARE_MUL_WAIT_EN.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;

    localparam int DATA_W     = 32;
    localparam int MUL_CYCLES = 4;
`ifdef ALU_SHARE_MUL_WAIT_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] p_op1 [2];
    logic [DATA_W-1:0] p_op2 [2];
    logic [5:0]        p_opcode [2];
    logic [5:0]        p_ar [2];
    logic [4:0]        p_sh [2];
    logic [DATA_W-1:0] alu_op1, alu_op2, alu_result, rsp_data;
    logic [5:0]        alu_opcode, alu_ar_op;
    logic [4:0]        alu_shamt;
    logic [1:0]        rsp_valid, rsp_ready, dbg_state;
    logic              busy;

    alu_share_ctrl #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1_0(p_op1[0]), .req_op2_0(p_op2[0]),
        .req_op1_1(p_op1[1]), .req_op2_1(p_op2[1]),
        .req_opcode_0(p_opcode[0]), .req_ar_op_0(p_ar[0]),
        .req_opcode_1(p_opcode[1]), .req_ar_op_1(p_ar[1]),
        .req_shamt_0(p_sh[0]), .req_shamt_1(p_sh[1]),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_opcode(alu_opcode), .alu_ar_op(alu_ar_op), .alu_shamt(alu_shamt),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- behavioural ALU ----------------
    function automatic logic [DATA_W-1:0] alu_fn(input logic [5:0] opc, input logic [5:0] ar,
                                                 input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input logic [4:0] sh);
        case (opc)
            6'b000000: begin
                case (ar)
                    6'b100001: return a + b;
                    6'b100011: return a - b;
                    6'b000000: return b << sh;
                    6'b101010: return ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
                    6'b100100: return a & b;
                    6'b100101: return a | b;
                    default:   return '0;
                endcase
            end
            6'b001010: return ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
            6'b011100: return a * b;
            default:   return '0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_opcode, alu_ar_op, alu_op1, alu_op2, alu_shamt);

    // ---------------- scoreboard / bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int last_grant;
    logic [DATA_W+1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic [5:0] opc, input logic [5:0] ar,
                            input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [4:0] sh);
        p_opcode[p] = opc;
        p_ar[p]     = ar;
        p_op1[p]    = a;
        p_op2[p]    = b;
        p_sh[p]     = sh;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_grant = 1;
    endtask

    // Serves one operation on port w; called at posedge+1 with the DUT idle.
    task automatic serve(input int w, input logic [DATA_W-1:0] exp, input int hold);
        int cyc;
        int lat;
        int exp_lat;
        logic [1:0] oh;
        oh      = 2'(1 << w);
        exp_lat = (MUL_EN && p_opcode[w] == 6'b011100) ? MUL_CYCLES : 1;
        cyc     = 0;
        @(negedge clk);
        while (req_ready[w] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("grant", req_ready, oh);
        check("grant_wait", cyc, 0);
        if (cyc >= 20) return;
        @(posedge clk);
        #1;
        req_valid[w] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (rsp_valid === 2'b00 && lat < 40) begin
            check("exec_op1", alu_op1, p_op1[w]);
            check("exec_op2", alu_op2, p_op2[w]);
            check("exec_opcode", {alu_opcode, alu_ar_op, alu_shamt}, {p_opcode[w], p_ar[w], p_sh[w]});
            check("exec_busy", busy, 1);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, exp_lat);
        check("rsp_valid", rsp_valid, oh);
        check("rsp_data", rsp_data, exp);
        for (int h = 0; h < hold; h++) begin
            rsp_ready[1-w] = h[0];
            @(negedge clk);
            check("hold_valid", rsp_valid, oh);
            check("hold_data", rsp_data, exp);
            check("hold_req_ready", req_ready, 2'b00);
        end
        rsp_ready = oh;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 2'b00);
    endtask

    // Round-robin reference: a tie goes to the port not granted last time.
    task automatic run_batch(input logic [1:0] mask, input logic [DATA_W-1:0] exp0,
                             input logic [DATA_W-1:0] exp1, input int hold);
        logic [1:0] pend;
        int w;
        pend      = mask;
        req_valid = mask;
        while (pend != 2'b00) begin
            w = (pend == 2'b11) ? 1 - last_grant : (pend[1] ? 1 : 0);
            serve(w, (w == 1) ? exp1 : exp0, hold);
            pend[w]    = 1'b0;
            last_grant = w;
        end
    endtask

    task automatic rand_port(input int p);
        logic [5:0] opc;
        logic [5:0] ar;
        case ($urandom_range(0, 6))
            0: begin opc = 6'b000000; ar = 6'b100001; end
            1: begin opc = 6'b000000; ar = 6'b100011; end
            2: begin opc = 6'b000000; ar = 6'b000000; end
            3: begin opc = 6'b000000; ar = 6'b101010; end
            4: begin opc = 6'b001010; ar = 6'b000000; end
            5: begin opc = 6'b011100; ar = 6'b000000; end
            default: begin opc = 6'b000000; ar = 6'b100101; end
        endcase
        set_port(p, opc, ar, $urandom, $urandom, 5'($urandom_range(0, 31)));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int                port;
        logic [5:0]        opcode;
        logic [5:0]        ar_op;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DATA_W+1:0] got;
        int last_t;
        vecs[0] = '{0, 6'b000000, 6'b100001, 32'd5,        32'd7,        5'd0, 32'd12};
        vecs[1] = '{0, 6'b000000, 6'b100011, 32'd9,        32'd4,        5'd0, 32'd5};
        vecs[2] = '{1, 6'b001010, 6'b000000, 32'd3,        32'd8,        5'd0, 32'd1};
        vecs[3] = '{0, 6'b000000, 6'b000000, 32'd0,        32'd1,        5'd4, 32'd16};
        vecs[4] = '{1, 6'b011100, 6'b000000, 32'd6,        32'd7,        5'd0, 32'd42};
        vecs[5] = '{1, 6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd2,        5'd0, 32'd1};
        vecs[6] = '{0, 6'b000000, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000};
        vecs[7] = '{1, 6'b000000, 6'b100001, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd0};
        vecs[8] = '{0, 6'b001010, 6'b000000, 32'd8,        32'd3,        5'd0, 32'd0};

        for (int p = 0; p < 2; p++) set_port(p, 6'd0, 6'd0, '0, '0, 5'd0);

        // Reset values while rst_n is held low, with both requests valid.
        rst_n     = 1'b0;
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_state", dbg_state, 2'd0);
        check("rst_alu", {alu_op1, alu_op2, alu_opcode, alu_ar_op, alu_shamt}, '0);
        check("rst_rsp_data", rsp_data, '0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        last_grant = 1;

        // Table-driven single-port operations.
        for (int i = 0; i < 9; i++) begin
            set_port(vecs[i].port, vecs[i].opcode, vecs[i].ar_op, vecs[i].op1, vecs[i].op2, vecs[i].shamt);
            if (vecs[i].port == 0) run_batch(2'b01, vecs[i].exp, '0, i % 3);
            else                   run_batch(2'b10, '0, vecs[i].exp, i % 3);
        end

        // Response backpressure with port 1 waiting and wrong-owner rsp_ready.
        do_reset();
        set_port(0, 6'b000000, 6'b100001, 32'd5, 32'd7, 5'd0);
        set_port(1, 6'b001010, 6'b000000, 32'd3, 32'd8, 5'd0);
        run_batch(2'b11, 32'd12, 32'd1, 5);

        // Continuous contention at full throughput: 0,1,0,1 every 3 cycles.
        do_reset();
        set_port(0, 6'b000000, 6'b100011, 32'd9, 32'd4, 5'd0);
        set_port(1, 6'b001010, 6'b000000, 32'd3, 32'd8, 5'd0);
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({2'b01, 32'd5});
            exp_q.push_back({2'b10, 32'd1});
        end
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        last_t    = -1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            check("ready_onehot", (req_ready == 2'b11), 0);
            if (rsp_valid != 2'b00) begin
                got = {rsp_valid, rsp_data};
                if (exp_q.size() == 0) check("extra_rsp", rsp_valid, 2'b00);
                else check("contention_rsp", got, exp_q.pop_front());
                if (last_t >= 0) check("rsp_spacing", c - last_t, 3);
                last_t = c;
            end
        end
        check("contention_count", exp_q.size(), 0);

        // Reset in the middle of EXEC drops the operation.
        do_reset();
        set_port(0, 6'b011100, 6'b000000, 32'd6, 32'd7, 5'd0);
        req_valid = 2'b01;
        @(negedge clk);
        check("mid_grant", req_ready, 2'b01);
        @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", dbg_state, 2'd0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 2'b00);
        check("mid_rst_alu_op1", alu_op1, '0);
        check("mid_rst_req_ready", req_ready, 2'b00);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("dropped_no_rsp", rsp_valid, 2'b00);
        end
        @(posedge clk);
        #1;
        last_grant = 1;
        set_port(0, 6'b000000, 6'b100001, 32'd5, 32'd7, 5'd0);
        run_batch(2'b01, 32'd12, '0, 0);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            logic [1:0] mask;
            mask = 2'($urandom_range(1, 3));
            rand_port(0);
            rand_port(1);
            run_batch(mask,
                      alu_fn(p_opcode[0], p_ar[0], p_op1[0], p_op2[0], p_sh[0]),
                      alu_fn(p_opcode[1], p_ar[1], p_op1[1], p_op2[1], p_sh[1]),
                      $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter that shares one combinational `alu` instance between two requesters, e.g. the execute stage (port 0) and an address-generation or coprocessor path (port 1). It accepts one operation at a time via valid/ready, drives registered operands and opcode fields to the ALU, and holds the ALU inputs stable for the required number of cycles. It captures `data_out_alu` into a result register and returns it to the winning requester with a valid/ready response handshake.

## Interface

- `DATA_W`, 32: operand/result width.
- `MUL_CYCLES`, 4: cycles ALU inputs are held for MUL (opcode 6'b011100) when the MUL wait feature is compiled in; legal range 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  per-requester operation valid.
- `req_ready[1:0]`  out  2  per-requester accept; at most one bit high.
- `req_op1_0`, `req_op2_0`, `req_op1_1`, `req_op2_1`  in  DATA_W each  operands per requester.
- `req_opcode_0`, `req_ar_op_0`, `req_opcode_1`, `req_ar_op_1`  in  6 each  opcode / funct fields.
- `req_shamt_0`, `req_shamt_1`  in  5 each  shift amount.
- `alu_op1`, `alu_op2`  out  DATA_W  to ALU.
- `alu_opcode`, `alu_ar_op`  out  6  to ALU.
- `alu_shamt`  out  5  to ALU.
- `alu_result`  in  DATA_W  from ALU `data_out_alu`.
- `rsp_valid[1:0]`  out  2  result valid for requester i; at most one bit high.
- `rsp_data`  out  DATA_W  result register.
- `rsp_ready[1:0]`  in  2  requester accepts result.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, EXEC, RESP.
- IDLE: grant is combinational. If exactly one `req_valid` bit is set, that requester wins. If both are set, the requester indicated by priority pointer `prio` wins. `req_ready[grant]` is high only in IDLE with `req_valid[grant]` high.
- Accept: at the edge where `req_valid[i] & req_ready[i]` is high, capture that requester's op1/op2/opcode/ar_op/shamt into operand registers, record `owner = i`, set `prio = ~i`, load `cnt`, and go to EXEC.
- `cnt` load value: MUL_CYCLES-1 for MUL with the feature compiled in; 0 otherwise.
- EXEC: `alu_*` outputs are driven directly from the operand registers and are stable for the whole state. If `cnt != 0`, decrement `cnt`. If `cnt == 0`, capture `alu_result` into `rsp_data` and go to RESP.
- RESP: `rsp_valid[owner]` = 1 and `rsp_data` is stable. On `rsp_ready[owner]`, go to IDLE. `rsp_ready` of the non-owner is ignored. No new request is accepted in RESP.
- Operand registers keep their last value outside EXEC. No toggling is required.
- No arithmetic is done in this block. Widths pass through unchanged.

## Timing

- Reset (asynchronous, any state, including mid-EXEC/RESP):
  - state=IDLE, `prio`=0, `owner`=0, `cnt`=0.
  - Operand registers, `rsp_data` = 0; therefore all `alu_*` outputs = 0.
  - `req_ready`=0 only while `rst_n` is low, then combinational from IDLE.
  - `rsp_valid`=0, `busy`=0.
  - An in-flight operation is dropped with no response.
- Non-MUL latency: accept at edge E0 → EXEC for 1 cycle → `rsp_data` captured at E1 → `rsp_valid` high from E1.
- MUL latency (feature compiled in): `rsp_valid` high from edge E0+MUL_CYCLES.
- Throughput: minimum 3 cycles per operation (IDLE, EXEC, RESP with `rsp_ready` already high).
- A request must not be withdrawn or changed while valid and not ready. The block does not check this.
- Round-robin: a requester that was granted loses priority on the next simultaneous request. Fairness: under continuous contention, grants alternate 0,1,0,1.

## Configuration

- `ALU_SHARE_MUL_WAIT_EN`:
  - Defined: MUL (opcode 6'b011100) holds EXEC for MUL_CYCLES cycles, to cover a multi-cycle or retimed multiplier.
  - Undefined: every opcode uses a single EXEC cycle, `cnt` logic is removed, and MUL_CYCLES is ignored.

## Test plan

- Reset: assert `rst_n`=0 mid-EXEC → state IDLE, `busy`=0, `rsp_valid`=0, `alu_op1`=0. After release, a port-0 ADDU request (ar_op 6'b100001, 5+7) yields `rsp_data`=12 on `rsp_valid[0]` one cycle after accept.
- Contention: both valid every cycle, `rsp_ready`=2'b11 → grants alternate 0,1,0,1 starting with 0 after reset. Each `rsp_valid` bit pairs with its own operands: port 0 SUB 9-4 → 5; port 1 SLT opcode 6'b001010, 3<8 → 1.
- Response backpressure: hold `rsp_ready[0]`=0 for 5 cycles → `rsp_valid[0]` and `rsp_data` stable, `req_ready`=0 for port 1 although it is valid. Release → IDLE next cycle, then port 1 is granted.
- MUL with `ALU_SHARE_MUL_WAIT_EN`, MUL_CYCLES=4: 6*7 → `alu_*` stable for 4 cycles, `rsp_data`=42 at E0+4. Without the macro: `rsp_data`=42 at E0+1.
- Shift: ar_op 6'b000000, op1=0, op2=1, shamt=4 → `rsp_data`=16. Wrong-owner `rsp_ready[1]`=1 while owner=0 → no state change.
